// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment BCD conversion path.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } seg_state_t;

    localparam logic [3:0] BLANK_CODE     = 4'hF;
    localparam logic [3:0] ADD3_THRESHOLD = 4'd5;
    localparam logic [3:0] NINE_CODE      = 4'h9;

endpackage

// File: rtl/bcd_add3_adjust.sv
// One-nibble double-dabble correction: add 3 when the digit is 5 or more,
// so the following left shift carries into the next decade.
module bcd_add3_adjust
    import seg_pkg::*;
(
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    assign adjusted = (digit >= ADD3_THRESHOLD) ? digit + 4'd3 : digit;

endmodule

// File: rtl/seg_bcd_converter.sv
// Serial binary-to-BCD converter (shift-add-3, MSB first) with valid/ready handshakes.
// Optional leading-zero blanking is enabled by defining SEG_LEADING_ZERO_BLANK_EN.
module seg_bcd_converter
    import seg_pkg::*;
#(
    parameter int BinWidth     = 14,
    parameter int NumberOfDisp = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BinWidth-1:0]       in_bin,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [4*NumberOfDisp-1:0] out_bcd,
    output logic                      out_overflow
);

    localparam int CntWidth = $clog2(BinWidth + 1);
    localparam int BcdWidth = 4 * NumberOfDisp;

    seg_state_t          state;
    logic [BinWidth-1:0] bin_sr;
    logic [BcdWidth-1:0] bcd_sr;
    logic [BcdWidth-1:0] bcd_adj;
    logic [BcdWidth-1:0] bcd_next;
    logic [BcdWidth-1:0] bcd_final;
    logic [CntWidth-1:0] count;
    logic                overflow;
    logic                overflow_next;
    logic                last_shift;

    for (genvar i = 0; i < NumberOfDisp; i++) begin : g_adjust
        bcd_add3_adjust u_adjust (
            .digit   (bcd_sr[4*i +: 4]),
            .adjusted(bcd_adj[4*i +: 4])
        );
    end

    // A bit leaving the top digit means the value needs more displays than we have.
    assign bcd_next      = {bcd_adj[BcdWidth-2:0], bin_sr[BinWidth-1]};
    assign overflow_next = overflow | bcd_adj[BcdWidth-1];
    assign last_shift    = (count == CntWidth'(BinWidth - 1));

    always_comb begin
`ifdef SEG_LEADING_ZERO_BLANK_EN
        logic leading;
        leading   = 1'b1;
        bcd_final = bcd_next;
        for (int i = NumberOfDisp - 1; i > 0; i--) begin
            if (leading && (bcd_next[4*i +: 4] == 4'd0)) begin
                bcd_final[4*i +: 4] = BLANK_CODE;
            end else begin
                leading = 1'b0;
            end
        end
`else
        bcd_final = bcd_next;
`endif
        if (overflow_next) begin
            bcd_final = {NumberOfDisp{NINE_CODE}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_bcd      <= '0;
            out_overflow <= 1'b0;
            bin_sr       <= '0;
            bcd_sr       <= '0;
            count        <= '0;
            overflow     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        bin_sr   <= in_bin;
                        bcd_sr   <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                        in_ready <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd_sr   <= bcd_next;
                    bin_sr   <= bin_sr << 1;
                    count    <= count + 1'b1;
                    overflow <= overflow_next;
                    if (last_shift) begin
                        out_bcd      <= bcd_final;
                        out_overflow <= overflow_next;
                        out_valid    <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_bcd_converter.sv
// Self-checking bench for seg_bcd_converter: vector table, scoreboard, and handshake/reset corner cases.
// Honours SEG_LEADING_ZERO_BLANK_EN the same way as the design.
module tb_seg_bcd_converter;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam bit Blank = 1'b1;
`else
    localparam bit Blank = 1'b0;
`endif
    localparam int Latency = 14;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [13:0] in_bin = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_bcd;
    logic        out_overflow;

    typedef struct {
        logic [13:0] bin;
        logic [15:0] bcd;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [13:0] bin;
        logic [15:0] bcd;
        logic        ovf;
        int          accept;
    } exp_t;

    vec_t vecs[12];
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cycle = 0;
    logic prev_valid = 1'b0;

    seg_bcd_converter #(.BinWidth(14), .NumberOfDisp(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_bin      (in_bin),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_bcd     (out_bcd),
        .out_overflow(out_overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at cycle %0d", name, actual, expected, cycle);
        end
    endtask

    // Reference built from decimal division, independent of the shift-add-3 method.
    function automatic logic [16:0] model(input int v);
        logic [3:0] d[4];
        logic lead;
        if (v > 9999) return {1'b1, 16'h9999};
        d[3] = 4'(v / 1000);
        d[2] = 4'((v / 100) % 10);
        d[1] = 4'((v / 10) % 10);
        d[0] = 4'(v % 10);
        if (Blank) begin
            lead = 1'b1;
            for (int i = 3; i > 0; i--) begin
                if (lead && d[i] == 4'd0) d[i] = 4'hF;
                else lead = 1'b0;
            end
        end
        return {1'b0, d[3], d[2], d[1], d[0]};
    endfunction

    task automatic applyStimulus(input logic [13:0] v, input logic [15:0] eb, input logic eo);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout in_ready=%0b required=1", in_ready);
            return;
        end
        in_valid = 1'b1;
        in_bin   = v;
        @(posedge clk);
        #1;
        sb.push_back('{v, eb, eo, cycle});
        in_valid = 1'b0;
        in_bin   = 14'($urandom);
    endtask

    task automatic drainScoreboard();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) checkOutput("ready_valid_exclusive", {63'd0, in_ready}, 64'd0);
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_out_valid out_valid=1 required=0 at cycle %0d", cycle);
                end else begin
                    checkOutput("latency", 64'(cycle - sb[0].accept), 64'(Latency));
                end
            end
            if (out_valid && out_ready && sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("out_bcd", {48'd0, out_bcd}, {48'd0, e.bcd});
                checkOutput("out_overflow", {63'd0, out_overflow}, {63'd0, e.ovf});
            end
        end
        prev_valid = out_valid;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [16:0] m;
        int n;
        vecs[0]  = '{14'd1234,  16'h1234, 1'b0};
        vecs[1]  = '{14'd12000, 16'h9999, 1'b1};
        vecs[2]  = '{14'd9999,  16'h9999, 1'b0};
        vecs[3]  = '{14'd10000, 16'h9999, 1'b1};
        vecs[4]  = '{14'd16383, 16'h9999, 1'b1};
        vecs[5]  = '{14'd7,     Blank ? 16'hFFF7 : 16'h0007, 1'b0};
        vecs[6]  = '{14'd0,     Blank ? 16'hFFF0 : 16'h0000, 1'b0};
        vecs[7]  = '{14'd42,    Blank ? 16'hFF42 : 16'h0042, 1'b0};
        vecs[8]  = '{14'd1000,  16'h1000, 1'b0};
        vecs[9]  = '{14'd305,   Blank ? 16'hF305 : 16'h0305, 1'b0};
        vecs[10] = '{14'd9,     Blank ? 16'hFFF9 : 16'h0009, 1'b0};
        vecs[11] = '{14'd8090,  16'h8090, 1'b0};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("reset_out_bcd", {48'd0, out_bcd}, 64'd0);
        checkOutput("reset_out_overflow", {63'd0, out_overflow}, 64'd0);

        $display("[TB] vector table");
        for (int i = 0; i < 12; i++) applyStimulus(vecs[i].bin, vecs[i].bcd, vecs[i].ovf);
        drainScoreboard();

        $display("[TB] backpressure hold");
        out_ready = 1'b0;
        applyStimulus(14'd4321, 16'h4321, 1'b0);
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("hold_reached_done", {63'd0, out_valid}, 64'd1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            in_valid = i[0];
            in_bin   = 14'($urandom);
            @(negedge clk);
            checkOutput("hold_out_bcd", {48'd0, out_bcd}, 64'h4321);
            checkOutput("hold_out_valid", {63'd0, out_valid}, 64'd1);
            checkOutput("hold_in_ready", {63'd0, in_ready}, 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("release_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("release_in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("release_sb_empty", 64'(sb.size()), 64'd0);

        $display("[TB] reset during shift");
        applyStimulus(14'd1234, 16'h1234, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b1;
        in_bin   = 14'd9999;
        @(posedge clk);
        #1;
        rst = 1'b0;
        void'(sb.pop_front());
        @(negedge clk);
        checkOutput("midreset_in_ready", {63'd0, in_ready}, 64'd1);
        checkOutput("midreset_out_valid", {63'd0, out_valid}, 64'd0);
        @(posedge clk);
        #1;
        sb.push_back('{14'd9999, 16'h9999, 1'b0, cycle});
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_accept", {63'd0, in_ready}, 64'd0);
        drainScoreboard();

        $display("[TB] back-to-back sweep");
        for (int v = 0; v < 300; v++) begin
            m = model(v);
            applyStimulus(14'(v), m[15:0], m[16]);
        end
        for (int v = 9900; v < 10012; v++) begin
            m = model(v);
            applyStimulus(14'(v), m[15:0], m[16]);
        end
        for (int k = 0; k < 60; k++) begin
            int v;
            v = int'($urandom_range(16383, 0));
            m = model(v);
            applyStimulus(14'(v), m[15:0], m[16]);
        end
        drainScoreboard();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
